// File: rtl/apb_irq_arbiter.sv
// Priority arbiter with APB claim/complete sequencing behind the interrupt-status block.
// Define APB_IRQ_ARB_RR_EN to start each scan after the last claimed source (round-robin among equals).
module apb_irq_arbiter #(
    parameter int NSRC   = 32,
    parameter int PRIO_W = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S_APB_PSEL,
    input  logic              S_APB_PENABLE,
    input  logic              S_APB_PWRITE,
    input  logic [15:0]       S_APB_PADDR,
    input  logic [31:0]       S_APB_PWDATA,
    output logic              S_APB_PREADY,
    output logic [31:0]       S_APB_PRDATA,
    output logic              S_APB_PSLVERR,
    input  logic [NSRC-1:0]   INT_PEND,
    output logic [NSRC-1:0]   INT_CLR,
    output logic              IRQ
);

    typedef enum logic {SCAN, DONE} state_t;

    localparam logic [4:0] LAST_ID = 5'(NSRC - 1);

    state_t              r_state, w_state_nxt;
    logic [PRIO_W-1:0]   r_prio [NSRC];
    logic [PRIO_W-1:0]   r_thresh;
    logic [NSRC-1:0]     r_insvc;
    logic [NSRC-1:0]     r_clr;
    logic [4:0]          r_idx, r_cnt, r_run_id, r_best_id, r_claim_id;
    logic [PRIO_W-1:0]   r_run_prio, r_best_prio;
    logic                r_rd_wait, r_claim_rd, r_claim_hit;
    logic [31:0]         r_prdata;

    logic                w_wr, w_rd_first, w_rd_ack;
    logic [13:0]         w_word;
    logic [4:0]          w_prio_idx, w_cmpl_id, w_start;
    logic                w_is_prio, w_is_thresh, w_is_claim, w_is_insvc;
    logic                w_valid, w_claim_ok, w_claim_fire, w_cmpl, w_cfg_wr, w_restart;
    logic [PRIO_W-1:0]   w_cand_prio;
    logic                w_elig, w_last_step, w_scan_step, w_latch;
    logic [NSRC-1:0]     w_onehot;
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_wr        = S_APB_PSEL & S_APB_PENABLE & S_APB_PWRITE;
    assign w_rd_first  = S_APB_PSEL & S_APB_PENABLE & ~S_APB_PWRITE & ~r_rd_wait;
    assign w_rd_ack    = S_APB_PSEL & S_APB_PENABLE & ~S_APB_PWRITE & r_rd_wait;
    assign w_word      = S_APB_PADDR[15:2];
    assign w_prio_idx  = S_APB_PADDR[6:2];
    assign w_is_prio   = w_word < 14'(NSRC);
    assign w_is_thresh = w_word == 14'h20;
    assign w_is_claim  = w_word == 14'h21;
    assign w_is_insvc  = w_word == 14'h22;
    assign w_cmpl_id   = S_APB_PWDATA[4:0];
    assign w_unused    = &{1'b0, S_APB_PADDR[1:0], S_APB_PWDATA};

    assign w_valid      = r_best_prio != '0;
    assign w_claim_ok   = w_valid & INT_PEND[r_best_id];
    assign w_claim_fire = w_rd_ack & r_claim_hit;
    assign w_cmpl       = w_wr & w_is_claim & (32'(w_cmpl_id) < NSRC) & r_insvc[w_cmpl_id];
    assign w_cfg_wr     = w_wr & (w_is_prio | w_is_thresh);
    assign w_restart    = w_cfg_wr | w_cmpl | (w_rd_ack & r_claim_rd);
    assign w_onehot     = {{(NSRC-1){1'b0}}, 1'b1} << r_claim_id;

    assign w_cand_prio = r_prio[r_idx];
    assign w_elig      = INT_PEND[r_idx] & ~r_insvc[r_idx] & (w_cand_prio > r_thresh);
    assign w_last_step = r_cnt == LAST_ID;

`ifdef APB_IRQ_ARB_RR_EN
    logic [4:0] r_last, w_last_nxt;
    // A claim on this edge moves the start point of the scan it restarts.
    assign w_last_nxt = w_claim_fire ? r_claim_id : r_last;
    assign w_start    = (w_last_nxt == LAST_ID) ? '0 : w_last_nxt + 5'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)               r_last <= LAST_ID;
        else if (w_claim_fire) r_last <= r_claim_id;
    end
`else
    assign w_start = '0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= SCAN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_restart) begin
            w_state_nxt = SCAN;
        end else begin
            case (r_state)
                SCAN:    if (w_last_step) w_state_nxt = DONE;
                DONE:    w_state_nxt = SCAN;
                default: w_state_nxt = SCAN;
            endcase
        end
    end

    always_comb begin
        w_scan_step = (r_state == SCAN) & ~w_restart;
        w_latch     = (r_state == DONE) & ~w_restart;
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_prio)        w_rdata = 32'(r_prio[w_prio_idx]);
        else if (w_is_thresh) w_rdata = 32'(r_thresh);
        else if (w_is_claim)  w_rdata = w_claim_ok ? {1'b1, 26'b0, r_best_id} : '0;
        else if (w_is_insvc)  w_rdata = 32'(r_insvc);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i < NSRC; i++) r_prio[i] <= '0;
            r_thresh    <= '0;
            r_insvc     <= '0;
            r_clr       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_run_id    <= '0;
            r_run_prio  <= '0;
            r_best_id   <= '0;
            r_best_prio <= '0;
            r_claim_id  <= '0;
            r_rd_wait   <= 1'b0;
            r_claim_rd  <= 1'b0;
            r_claim_hit <= 1'b0;
            r_prdata    <= '0;
        end else begin
            r_rd_wait <= w_rd_first;
            // Claim outcome is decided when read data is captured so data and side effect agree.
            if (w_rd_first) begin
                r_prdata    <= w_rdata;
                r_claim_rd  <= w_is_claim;
                r_claim_hit <= w_is_claim & w_claim_ok;
                r_claim_id  <= r_best_id;
            end
            r_clr <= w_claim_fire ? w_onehot : '0;

            if (w_wr & w_is_prio)   r_prio[w_prio_idx] <= S_APB_PWDATA[PRIO_W-1:0];
            if (w_wr & w_is_thresh) r_thresh <= S_APB_PWDATA[PRIO_W-1:0];
            if (w_claim_fire)       r_insvc[r_claim_id] <= 1'b1;
            if (w_cmpl)             r_insvc[w_cmpl_id] <= 1'b0;

            if (w_restart | w_latch) begin
                r_idx      <= w_start;
                r_cnt      <= '0;
                r_run_id   <= w_start;
                r_run_prio <= '0;
                if (w_restart) begin
                    r_best_prio <= '0;
                end else begin
                    r_best_id   <= r_run_id;
                    r_best_prio <= r_run_prio;
                end
            end else if (w_scan_step) begin
                r_idx <= (r_idx == LAST_ID) ? '0 : r_idx + 5'd1;
                r_cnt <= r_cnt + 5'd1;
                if (w_elig && (w_cand_prio > r_run_prio)) begin
                    r_run_id   <= r_idx;
                    r_run_prio <= w_cand_prio;
                end
            end
        end
    end

    assign IRQ           = w_valid;
    assign INT_CLR       = r_clr;
    assign S_APB_PREADY  = ~RST & (w_wr | w_rd_ack);
    assign S_APB_PRDATA  = w_rd_ack ? r_prdata : '0;
    assign S_APB_PSLVERR = 1'b0;

endmodule

// File: doc/apb_irq_arbiter.md
# apb_irq_arbiter

Priority arbiter and claim/complete sequencer placed behind the APB interrupt-status block. Takes the masked pending vector, finds the highest-priority pending source above a programmable threshold with a sequential scan, drives a single CPU interrupt line, and runs an APB claim/complete protocol. On claim it pulses a per-source clear back to the status block and marks the source in-service until software completes it.

## Interface
- NSRC, 32: number of interrupt sources, 2..32; source IDs are 0..NSRC-1.
- PRIO_W, 3: priority field width; priority 0 means never selected.
- CLK input 1: clock; all state on rising edge.
- RST input 1: asynchronous, active-high reset.
- S_APB_PSEL, S_APB_PENABLE, S_APB_PWRITE input 1: APB control.
- S_APB_PADDR input 16: byte address; bits [1:0] ignored.
- S_APB_PWDATA input 32: write data.
- S_APB_PREADY output 1: transfer complete.
- S_APB_PRDATA output 32: read data; 0 whenever PREADY is not asserted for a read.
- S_APB_PSLVERR output 1: constant 0.
- INT_PEND input NSRC: masked pending vector, level.
- INT_CLR output NSRC: one-cycle clear pulse to the status block, at most one bit set.
- IRQ output 1: interrupt request to the CPU.

## Operation
- Register map:
  - PRIO[i] at 0x0000+4*i, R/W, [PRIO_W-1:0].
  - THRESH at 0x0080, R/W, [PRIO_W-1:0].
  - CLAIM at 0x0084. A read claims. A write completes, with the ID in [4:0].
  - INSVC at 0x0088, RO, in-service bitmap.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Eligible source: INT_PEND[i]=1, insvc[i]=0, and PRIO[i]>THRESH.
- FSM states: SCAN, DONE.
  - SCAN visits one source per cycle for NSRC cycles. A candidate replaces the running best only if its priority is strictly greater.
  - DONE lasts one cycle. It latches best_id and best_prio and sets valid=1 if any source was eligible, else valid=0. It then returns to SCAN automatically (continuous re-scan).
- Restart: any PRIO/THRESH write, claim, or complete aborts the scan in progress, clears valid, and enters SCAN at its start index on the next cycle.
- IRQ = valid.
- Claim (read of CLAIM, on the ack cycle):
  - If valid and INT_PEND[best_id]=1:
    - PRDATA={1'b1, 26'b0, best_id[4:0]}.
    - insvc[best_id] is set.
    - INT_CLR[best_id] pulses in the following cycle.
    - Restart.
  - Otherwise PRDATA=0, there is no side effect, and restart still occurs.
- Complete (write of CLAIM): if ID<NSRC and insvc[ID]=1, clear insvc[ID] and restart. Otherwise ignored with no restart.

## Timing
- Reset values:
  - Outputs: IRQ=0, INT_CLR=0, PREADY=0, PRDATA=0.
  - State: all PRIO=0, THRESH=0, insvc=0, valid=0, FSM=SCAN at index 0.
- Write: PREADY=1 in the first access cycle (PSEL&PENABLE&PWRITE); the register updates on that edge.
- Read: one wait state. PREADY=1 in the second access cycle, with PRDATA registered from the first.
- Result latency: valid/IRQ rise NSRC+1 cycles after restart (SCAN NSRC cycles, then DONE). Result reflects INT_PEND sampled during the scan.
- IRQ drops the cycle after a claim ack, complete, or PRIO/THRESH write.
- INT_CLR is exactly one cycle wide, one cycle after the claim ack.
- A pending bit that drops after DONE is caught by the INT_PEND check at claim (returns 0).
- RST asserted mid-scan or mid-transfer immediately returns all state to reset values. An in-flight APB transfer is not acked.

## Configuration
- APB_IRQ_ARB_RR_EN defined: each scan starts at (last_claimed_id+1) mod NSRC, with last_claimed_id reset to NSRC-1. Equal-priority ties go to the first source found from that start, giving round-robin among equals.
- Not defined: scan always starts at 0, and ties go to the lowest ID.

## Test plan
- Reset, then PRIO[3]=2, PRIO[7]=5, THRESH=1, INT_PEND=0x88 -> IRQ=1 within NSRC+2 cycles of the last write; CLAIM read returns 0x80000007; INT_CLR=0x80 for one cycle; INSVC=0x80.
- Continuing, with INT_PEND bit 7 cleared -> after rescan IRQ=1 and CLAIM returns 0x80000003. Write CLAIM=7 -> INSVC=0x08. Write CLAIM=7 again -> ignored, INSVC unchanged.
- THRESH=5 with only source 7 (prio 5) pending -> IRQ stays 0; CLAIM read returns 0 with no INT_CLR.
- PRIO[1]=PRIO[2]=4, both pending, repeated claim+complete:
  - Without APB_IRQ_ARB_RR_EN: claims return 1, 1, 1.
  - With APB_IRQ_ARB_RR_EN: claims return 1, 2, 1.
- Source 4 pending with IRQ=1, INT_PEND[4] dropped before the CLAIM read -> read returns 0, no INT_CLR, IRQ=0 after rescan.
- RST pulsed during a scan and again during a read wait state -> all outputs 0 immediately; PRIO/THRESH/INSVC read back 0 afterwards.
